// File: rtl/enemy_collision.sv
// enemy_collision: per-frame player/enemy overlap scanner.
// On each frame tick the enemy slots are scanned in index order against the
// latched player position. The first active, overlapping slot found while the
// player is not invulnerable produces one hit: HP drops, the slot is asked to
// despawn and an invulnerability window of INVULN_FRAMES frames starts.
module enemy_collision #(
    parameter int NUM_ENEMY     = 4,
    parameter int HIT_DX        = 20,
    parameter int HIT_DY        = 20,
    parameter int MAX_HP        = 5,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frameTick,
    input  logic [9:0]             playerX,
    input  logic [8:0]             playerY,
    input  logic [NUM_ENEMY-1:0]   enemyActive,
    input  logic [10*NUM_ENEMY-1:0] enemyXBus,
    input  logic [9*NUM_ENEMY-1:0] enemyYBus,
    output logic [3:0]             hp,
    output logic                   hitPulse,
    output logic                   killValid,
    output logic [3:0]             killUid,
    output logic                   invulnerable,
    output logic                   gameOver,
    output logic                   busy
);

    localparam logic [10:0] HIT_DX_W   = 11'(HIT_DX);
    localparam logic [9:0]  HIT_DY_W   = 10'(HIT_DY);
    localparam logic [3:0]  MAX_HP_W   = 4'(MAX_HP);
    localparam logic [7:0]  INVULN_W   = 8'(INVULN_FRAMES);
    localparam logic [3:0]  LAST_IDX_W = 4'(NUM_ENEMY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_HIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [9:0]  px_q, px_d;
    logic [8:0]  py_q, py_d;
    logic [3:0]  hp_q, hp_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic        kill_valid_q, kill_valid_d;
    logic [3:0]  kill_uid_q, kill_uid_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        invuln_q, invuln_d;
    logic        game_over_q, game_over_d;
    logic        busy_q, busy_d;

    logic        sel_active_s;
    logic [9:0]  sel_x_s;
    logic [8:0]  sel_y_s;
    logic [10:0] dx_s;
    logic [9:0]  dy_s;
    logic        overlap_s;
    logic        invuln_now_s;

    // Select the slot currently being scanned and compute its overlap with the latched player box.
    always_comb begin
        sel_active_s = 1'b0;
        sel_x_s      = 10'd0;
        sel_y_s      = 9'd0;
        for (int i = 0; i < NUM_ENEMY; i++) begin
            sel_active_s = sel_active_s | (enemyActive[i] & (idx_q == 4'(i)));
            sel_x_s      = sel_x_s | (enemyXBus[10*i +: 10] & {10{idx_q == 4'(i)}});
            sel_y_s      = sel_y_s | (enemyYBus[9*i +: 9] & {9{idx_q == 4'(i)}});
        end
        dx_s = (sel_x_s >= px_q) ? ({1'b0, sel_x_s} - {1'b0, px_q})
                                 : ({1'b0, px_q} - {1'b0, sel_x_s});
        dy_s = (sel_y_s >= py_q) ? ({1'b0, sel_y_s} - {1'b0, py_q})
                                 : ({1'b0, py_q} - {1'b0, sel_y_s});
        overlap_s    = sel_active_s & (dx_s < HIT_DX_W) & (dy_s < HIT_DY_W);
        invuln_now_s = (cnt_q != 8'd0);
    end

    // Next-state logic for the scan FSM, HP, invulnerability counter and all registered outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        px_d         = px_q;
        py_d         = py_q;
        hp_d         = hp_q;
        hit_pulse_d  = 1'b0;
        kill_valid_d = 1'b0;
        kill_uid_d   = kill_uid_q;
        game_over_d  = game_over_q;
        // Frame ticks age the window in every state, including dropped ticks while busy.
        if (frameTick && invuln_now_s) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (frameTick && !game_over_q) begin
                    px_d    = playerX;
                    py_d    = playerY;
                    idx_d   = 4'd0;
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (overlap_s && !invuln_now_s) begin
                    // idx holds so it still names the colliding slot.
                    state_d      = S_HIT;
                    hit_pulse_d  = 1'b1;
                    kill_valid_d = 1'b1;
                    kill_uid_d   = idx_q;
                end else if (idx_q == LAST_IDX_W) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_HIT: begin
                // The fresh window load takes priority over a same-cycle decrement.
                cnt_d = INVULN_W;
                if (hp_q != 4'd0) begin
                    hp_d = hp_q - 4'd1;
                end else begin
                    hp_d = hp_q;
                end
                if (hp_q == 4'd1) begin
                    game_over_d = 1'b1;
                end else begin
                    game_over_d = game_over_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        invuln_d = (cnt_d != 8'd0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 4'd0;
            px_q         <= 10'd0;
            py_q         <= 9'd0;
            hp_q         <= MAX_HP_W;
            hit_pulse_q  <= 1'b0;
            kill_valid_q <= 1'b0;
            kill_uid_q   <= 4'd0;
            cnt_q        <= 8'd0;
            invuln_q     <= 1'b0;
            game_over_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            px_q         <= px_d;
            py_q         <= py_d;
            hp_q         <= hp_d;
            hit_pulse_q  <= hit_pulse_d;
            kill_valid_q <= kill_valid_d;
            kill_uid_q   <= kill_uid_d;
            cnt_q        <= cnt_d;
            invuln_q     <= invuln_d;
            game_over_q  <= game_over_d;
            busy_q       <= busy_d;
        end
    end

    assign hp           = hp_q;
    assign hitPulse     = hit_pulse_q;
    assign killValid    = kill_valid_q;
    assign killUid      = kill_uid_q;
    assign invulnerable = invuln_q;
    assign gameOver     = game_over_q;
    assign busy         = busy_q;

endmodule
